// File: rtl/csi_pkg.sv
// Shared definitions for the CSI capture controller: FSM states, err bit positions,
// qualified-event bit positions and CSI data-type codes.
package csi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_LINE     = 1;
  localparam int ERR_TIMEOUT  = 2;

  // Bit order of the packed {fs, fe, ls, le} event vectors.
  localparam int EV_FS = 3;
  localparam int EV_FE = 2;
  localparam int EV_LS = 1;
  localparam int EV_LE = 0;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

endpackage

// File: rtl/csi_capture_watchdog.sv
// Inactivity watchdog: counts cycles while active, restarts on clear, flags expiry combinationally
// on the cycle the count reaches TIMEOUT_CYCLES. No backpressure.
module csi_capture_watchdog #(
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || !active_i || clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = active_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/csi_capture_ctrl.sv
// CSI frame capture controller: payload strobe -> buffer write 1 cycle later, no backpressure.
// Optional watchdog enabled by defining CSI_CAPTURE_TIMEOUT_EN.
module csi_capture_ctrl
  import csi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_LINES      = 1080,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                  clock_p,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [11:0]           cfg_lines,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  line_start,
  input  logic                  line_end,
  input  logic                  valid_packet,
  input  logic [31:0]           image_data,
  input  logic                  image_data_enable,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic [11:0]           line_count,
  output logic [2:0]            err
);

  localparam logic [11:0] LINE_MAX = 12'(MAX_LINES);

  cap_state_e            state_q;
  logic [3:0]            lvl_q;
  logic [3:0]            lvl_now;
  logic [3:0]            ev;
  logic                  ev_fs, ev_fe, ev_ls, ev_le;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  full_q;
  logic [11:0]           line_cnt_q, line_cnt_d;
  logic [15:0]           frame_cnt_q;
  logic [2:0]            err_q;
  logic                  wr_en_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic                  wd_expired;

  assign lvl_now = {frame_start, frame_end, line_start, line_end} & {4{valid_packet}};
  assign ev      = lvl_now & ~lvl_q;
  assign ev_fs   = ev[EV_FS];
  assign ev_fe   = ev[EV_FE];
  assign ev_ls   = ev[EV_LS];
  assign ev_le   = ev[EV_LE];

  assign line_cnt_d = (ev_le && (line_cnt_q < LINE_MAX)) ? line_cnt_q + 12'd1 : line_cnt_q;

`ifdef CSI_CAPTURE_TIMEOUT_EN
  csi_capture_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clock_p),
    .reset_i  (reset),
    .active_i ((state_q == ST_ARMED) || (state_q == ST_FRAME)),
    .clear_i  (|ev),
    .expired_o(wd_expired)
  );
`else
  // Line-start only feeds the watchdog; without it the event is intentionally dropped.
  logic unused_ls;
  assign unused_ls  = ev_ls ^ (TIMEOUT_CYCLES > 0);
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock_p) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lvl_q       <= '0;
      ptr_q       <= '0;
      full_q      <= 1'b0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      lvl_q   <= lvl_now;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
      end else if (wd_expired) begin
        state_q             <= ST_IDLE;
        err_q[ERR_TIMEOUT]  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q    <= ST_ARMED;
              busy_q     <= 1'b1;
              err_q      <= '0;
              line_cnt_q <= '0;
              wr_addr_q  <= '0;
              ptr_q      <= '0;
              full_q     <= 1'b0;
            end
          end
          ST_ARMED: begin
            busy_q <= 1'b1;
            if (ev_fs) state_q <= ST_FRAME;
          end
          ST_FRAME: begin
            // The last buffer word is written, then the pointer parks instead of wrapping.
            if (image_data_enable && !full_q) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_data_q <= image_data;
              if (ptr_q == '1) begin
                full_q              <= 1'b1;
                err_q[ERR_OVERFLOW] <= 1'b1;
              end else begin
                ptr_q <= ptr_q + ADDR_WIDTH'(1);
              end
            end
            line_cnt_q <= line_cnt_d;
            if (ev_fs) begin
              ptr_q           <= '0;
              full_q          <= 1'b0;
              line_cnt_q      <= '0;
              err_q[ERR_LINE] <= 1'b1;
              busy_q          <= 1'b1;
            end else if (ev_fe) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              if ((cfg_lines != '0) && (line_cnt_d != cfg_lines)) err_q[ERR_LINE] <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
          ST_DONE: begin
            if (continuous) begin
              state_q    <= ST_ARMED;
              busy_q     <= 1'b1;
              ptr_q      <= '0;
              full_q     <= 1'b0;
              line_cnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_cnt_q;
  assign line_count  = line_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_csi_capture_ctrl.sv
// Bench for csi_capture_ctrl: directed frames with literal expectations plus random traffic,
// every cycle compared against a behavioural capture model.
module tb_csi_capture_ctrl;

  localparam int AW  = 4;
  localparam int ML  = 6;
  localparam int TMO = 100;
  localparam logic [3:0] P_FS = 4'b1000;
  localparam logic [3:0] P_FE = 4'b0100;
  localparam logic [3:0] P_LS = 4'b0010;
  localparam logic [3:0] P_LE = 4'b0001;

  logic          clock_p = 1'b0;
  logic          reset, start, stop, continuous;
  logic [11:0]   cfg_lines;
  logic          frame_start, frame_end, line_start, line_end, valid_packet;
  logic [31:0]   image_data;
  logic          image_data_enable;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy, done;
  logic [15:0]   frame_count;
  logic [11:0]   line_count;
  logic [2:0]    err;

  csi_capture_ctrl #(
    .ADDR_WIDTH(AW), .MAX_LINES(ML), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_p(clock_p), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .cfg_lines(cfg_lines), .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end), .valid_packet(valid_packet),
    .image_data(image_data), .image_data_enable(image_data_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .frame_count(frame_count), .line_count(line_count), .err(err)
  );

  always #5 clock_p = ~clock_p;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen, done_seen;
  int addr_log[$];

  // Behavioural model: phase 0 idle, 1 armed, 2 in frame, 3 frame just finished.
  int          m_phase, m_ptr, m_lines, m_frames, m_wd;
  bit          m_full;
  logic [3:0]  m_prev;
  logic [2:0]  m_err;
  logic        e_wr_en;
  int          e_addr;
  logic [31:0] e_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] q, ev;
    bit expired;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_lines = 0; m_frames = 0; m_wd = 0; m_full = 0;
      m_prev = '0; m_err = '0; e_wr_en = 0; e_addr = 0; e_data = '0;
      return;
    end
    q = {frame_start, frame_end, line_start, line_end} & {4{valid_packet}};
    ev = q & ~m_prev;
    m_prev = q;
    expired = 0;
`ifdef CSI_CAPTURE_TIMEOUT_EN
    if ((m_phase == 1 || m_phase == 2) && ev == 4'b0) begin
      if (m_wd == TMO - 1) expired = 1;
      m_wd++;
    end else begin
      m_wd = 0;
    end
`endif
    e_wr_en = 0;
    if (stop) begin
      m_phase = 0;
    end else if (expired) begin
      m_phase = 0;
      m_err[2] = 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_err = '0; m_lines = 0; e_addr = 0; m_ptr = 0; m_full = 0;
      end
    end else if (m_phase == 1) begin
      if (ev[3]) m_phase = 2;
    end else if (m_phase == 2) begin
      if (image_data_enable && !m_full) begin
        e_wr_en = 1; e_addr = m_ptr; e_data = image_data;
        if (m_ptr == (1 << AW) - 1) begin
          m_full = 1; m_err[0] = 1'b1;
        end else begin
          m_ptr++;
        end
      end
      if (ev[0]) m_lines = (m_lines < ML) ? m_lines + 1 : ML;
      if (ev[3]) begin
        m_ptr = 0; m_full = 0; m_lines = 0; m_err[1] = 1'b1;
      end else if (ev[2]) begin
        m_frames = (m_frames + 1) % 65536;
        if (cfg_lines != 0 && m_lines != int'(cfg_lines)) m_err[1] = 1'b1;
        m_phase = 3;
      end
    end else begin
      if (continuous) begin
        m_phase = 1; m_ptr = 0; m_full = 0; m_lines = 0;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_p);
    #1;
    model_step();
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("frame_count", frame_count, m_frames);
    chk("line_count", line_count, m_lines);
    chk("err", err, m_err);
    if (wr_en) begin
      wr_seen++;
      addr_log.push_back(int'(wr_addr));
    end
    if (done) done_seen++;
  endtask

  task automatic clear_obs();
    wr_seen = 0; done_seen = 0; addr_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_ev(input logic [3:0] m, input logic vp);
    {frame_start, frame_end, line_start, line_end} = m;
    valid_packet = vp;
    tick();
    {frame_start, frame_end, line_start, line_end} = 4'b0;
    valid_packet = 1'b0;
    tick();
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) begin
      image_data = $urandom;
      image_data_enable = 1'b1;
      tick();
    end
    image_data_enable = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int wpl);
    pulse_ev(P_FS, 1'b1);
    for (int l = 0; l < lines; l++) begin
      pulse_ev(P_LS, 1'b1);
      words(wpl);
      pulse_ev(P_LE, 1'b1);
    end
    pulse_ev(P_FE, 1'b1);
  endtask

  function automatic int log_at(input int i);
    return (addr_log.size() > i) ? addr_log[i] : -1;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; cfg_lines = '0;
    {frame_start, frame_end, line_start, line_end} = 4'b0;
    valid_packet = 1'b0; image_data = '0; image_data_enable = 1'b0;

    do_reset();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_err", err, 0);

    // Nominal frame, line count matches.
    cfg_lines = 12'd4;
    pulse_start();
    chk("start_busy", busy, 1);
    send_frame(4, 3);
    chk("nom_writes", wr_seen, 12);
    chk("nom_first_addr", log_at(0), 0);
    chk("nom_last_addr", log_at(11), 11);
    chk("nom_done", done_seen, 1);
    chk("nom_frame_count", frame_count, 1);
    chk("nom_err", err, 3'b000);
    chk("nom_idle", busy, 0);

    // Line count mismatch.
    do_reset();
    cfg_lines = 12'd5;
    pulse_start();
    send_frame(4, 3);
    chk("mis_done", done_seen, 1);
    chk("mis_err", err, 3'b010);

    // Continuous: two back-to-back frames.
    do_reset();
    cfg_lines = 12'd4;
    continuous = 1'b1;
    pulse_start();
    send_frame(4, 3);
    send_frame(4, 3);
    chk("cont_done", done_seen, 2);
    chk("cont_writes", wr_seen, 24);
    chk("cont_second_addr0", log_at(12), 0);
    chk("cont_frame_count", frame_count, 2);
    chk("cont_busy", busy, 1);
    continuous = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // Buffer overflow: 20 words into a 16-entry buffer.
    do_reset();
    cfg_lines = 12'd0;
    pulse_start();
    pulse_ev(P_FS, 1'b1);
    words(20);
    pulse_ev(P_FE, 1'b1);
    chk("ovf_writes", wr_seen, 16);
    chk("ovf_last_addr", log_at(15), 15);
    chk("ovf_err", err, 3'b001);
    chk("ovf_done", done_seen, 1);

    // Stop mid-frame, then unqualified events, restart, line saturation.
    do_reset();
    pulse_start();
    pulse_ev(P_FS, 1'b1);
    words(5);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    tick(); tick();
    chk("stop_no_done", done_seen, 0);
    pulse_start();
    clear_obs();
    pulse_ev(P_FS, 1'b0);
    words(3);
    chk("novalid_writes", wr_seen, 0);
    chk("novalid_busy", busy, 1);
    pulse_ev(P_FS, 1'b1);
    words(2);
    pulse_ev(P_FS, 1'b1);
    chk("restart_err", err, 3'b010);
    chk("restart_fc", frame_count, 0);
    words(1);
    chk("restart_addr", log_at(addr_log.size() - 1), 0);
    for (int i = 0; i < 8; i++) pulse_ev(P_LE, 1'b1);
    chk("sat_lines", line_count, ML);
    cfg_lines = 12'd6;
    pulse_ev(P_FE, 1'b1);
    chk("sat_fc", frame_count, 1);
    chk("sat_err_sticky", err, 3'b010);

`ifdef CSI_CAPTURE_TIMEOUT_EN
    do_reset();
    pulse_start();
    repeat (TMO - 1) tick();
    chk("wd_before", busy, 1);
    tick();
    chk("wd_busy", busy, 0);
    chk("wd_err", err, 3'b100);
`endif

    // Reset in the middle of a frame with data and fe pending.
    do_reset();
    pulse_start();
    pulse_ev(P_FS, 1'b1);
    words(2);
    image_data_enable = 1'b1; frame_end = 1'b1; valid_packet = 1'b1; reset = 1'b1;
    done_seen = 0;
    tick();
    image_data_enable = 1'b0; frame_end = 1'b0; valid_packet = 1'b0; reset = 1'b0;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lines", line_count, 0);
    chk("mid_rst_done", done_seen, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      if ($urandom_range(0, 11) == 0) frame_start = ~frame_start;
      if ($urandom_range(0, 9) == 0) frame_end = ~frame_end;
      if ($urandom_range(0, 5) == 0) line_start = ~line_start;
      if ($urandom_range(0, 4) == 0) line_end = ~line_end;
      valid_packet = ($urandom_range(0, 7) != 0);
      image_data_enable = $urandom_range(0, 1);
      image_data = $urandom;
      if ($urandom_range(0, 63) == 0) cfg_lines = 12'($urandom_range(0, 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_capture_ctrl.md
CSI_CAPTURE_CTRL -- requirements
Module: csi_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-address width of the capture buffer.
REQ-002 SHALL have parameter MAX_LINES, default 1080, upper bound accepted for cfg_lines.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2^20, watchdog limit.
REQ-004 clock_p  in  1  byte clock from the receiver; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start / stop / continuous  in  1 each  start capture (pulse), abort (pulse), re-arm after each frame (level).
REQ-007 cfg_lines  in  12  expected lines per frame; 0 means no check.
REQ-008 frame_start, frame_end, line_start, line_end, valid_packet  in  1 each  decoded header levels from the receiver.
REQ-009 image_data  in  32, image_data_enable  in  1  packed payload word and its one-cycle strobe.
REQ-010 wr_en  out 1, wr_addr  out ADDR_WIDTH, wr_data  out 32  buffer write port.
REQ-011 busy, done  out 1 each; frame_count  out 16; line_count  out 12; err  out 3 {timeout, line_mismatch, overflow}.

Function
REQ-012 SHALL register each event level ANDed with valid_packet and act only on its 0->1 edge (fs/fe/ls/le events).
REQ-013 FSM states SHALL be IDLE, ARMED, FRAME, DONE.
REQ-014 IDLE: start -> ARMED; clears err, line_count and wr_addr the same cycle.
REQ-015 ARMED: fs event -> FRAME; fe/ls/le events ignored.
REQ-016 FRAME: each image_data_enable SHALL produce wr_en=1 on the next cycle with wr_data = image_data and wr_addr = current pointer; the pointer then increments.
REQ-017 Latency image_data_enable -> wr_en SHALL be exactly 1 cycle.
REQ-018 Pointer at 2^ADDR_WIDTH-1: after that write, further writes are suppressed and err[0] is set (no wrap).
REQ-019 le event SHALL increment line_count, saturating at MAX_LINES.
REQ-020 FRAME: fe event -> DONE; frame_count increments (wraps at 16 bits); err[1] set if cfg_lines != 0 and line_count != cfg_lines.
REQ-021 DONE: done=1 for exactly one cycle; next state ARMED if continuous=1 (pointer and line_count cleared), else IDLE.
REQ-022 fs event in FRAME (missing fe) SHALL restart the frame: pointer and line_count cleared, err[1] set, frame_count unchanged.
REQ-023 stop in any state SHALL return to IDLE next cycle without asserting done; stop wins over a simultaneous start or event.
REQ-024 busy SHALL be 1 in ARMED and FRAME only.
REQ-025 An image_data_enable in the cycle of fe SHALL still be written.

Reset
REQ-026 reset SHALL force IDLE and the registered edge detectors to 0; wr_en, wr_addr, wr_data, busy, done, frame_count, line_count and err SHALL all be 0 one cycle later.
REQ-027 reset asserted mid-frame SHALL discard the frame with no done pulse.

Configuration
REQ-028 With CSI_CAPTURE_TIMEOUT_EN defined, a watchdog SHALL count cycles in ARMED/FRAME, clear on any qualified event, and on reaching TIMEOUT_CYCLES set err[2] and go to IDLE.
REQ-029 Without CSI_CAPTURE_TIMEOUT_EN, no watchdog logic SHALL exist and err[2] SHALL be constant 0.

Structure
REQ-030 The shared package csi_pkg SHALL hold the FSM state enum, the err bit indices and the CSI data-type constants (FS=0x00, FE=0x01, LS=0x02, LE=0x03, RAW10=0x2B).
REQ-031 The watchdog SHALL be the single sub-module csi_capture_watchdog, instantiated only under CSI_CAPTURE_TIMEOUT_EN.

Verification
REQ-032 start, fs, 4 lines x 3 words, fe, cfg_lines=4 -> 12 writes at addresses 0..11, done pulse, frame_count=1, err=0.
REQ-033 Same frame with cfg_lines=5 -> done pulse, err=3'b010.
REQ-034 continuous=1, two back-to-back frames -> two done pulses; second frame writes from address 0; frame_count=2.
REQ-035 ADDR_WIDTH=4, 20 words in one frame -> 16 writes, err[0]=1, done still pulses on fe.
REQ-036 stop after 5 words -> IDLE next cycle, no done pulse, busy=0; events with valid_packet=0 -> no state change.
REQ-037 With CSI_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100, start then no events -> err=3'b100 and IDLE at cycle 100; reset mid-frame -> all outputs 0 next cycle.
